prbs_checker: RTL and testbench

//  Receive-side checker for the serial stream from the lfsr generator. Self-synchronises
//  its own LFSR to the incoming bits, declares lock, then free-runs, counting bit errors.

---
 rtl/prbs_checker.sv | 148 ++++++++++++++
 tb/tb_prbs_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises an LFSR to the incoming stream,
// declares lock, then free-runs and counts bit errors.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-high reset
//   bitIn     received serial bit
//   bitValid  bitIn valid; all state advances only when high
//   tapIn     feedback tap mask (generator convention)
//   tapEn     load tapIn, restart acquisition from FILL
//   clearErr  synchronous clear of errCount
//   locked    high while in LOCKED
//   errPulse  one-cycle strobe on a mismatch while LOCKED
//   errCount  saturating mismatch count while LOCKED
//   state     FILL=00, VERIFY=01, LOCKED=10
module prbs_checker #(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bitIn,
    input  logic                 bitValid,
    input  logic [WIDTH-1:0]     tapIn,
    input  logic                 tapEn,
    input  logic                 clearErr,
    output logic                 locked,
    output logic                 errPulse,
    output logic [ERR_CNT_W-1:0] errCount,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);

    // Reset tap mask matches the generator's default polynomial for 8 bits.
    localparam logic [WIDTH-1:0] TAP_RST =
        (WIDTH == 8) ? WIDTH'(8'hB8) : '0;

    state_t                 st;
    logic [WIDTH-1:0]       shreg;
    logic [WIDTH-1:0]       taps;
    logic [FW-1:0]          fill_cnt;
    logic [MW-1:0]          match_cnt;
    logic [LW-1:0]          miss_cnt;
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic                   pred;

    assign pred     = ^(shreg & taps);
    assign state    = st;
    assign errCount = err_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= FILL;
            shreg     <= '0;
            taps      <= TAP_RST;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            errPulse  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            errPulse <= 1'b0;
            if (clearErr) begin
                err_cnt <= '0;
            end
            if (tapEn) begin
                // New polynomial: restart acquisition, ignore this bit.
                taps      <= tapIn;
                st        <= FILL;
                fill_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
            end else if (bitValid) begin
                unique case (st)
                    FILL: begin
                        shreg <= {shreg[WIDTH-2:0], bitIn};
                        if (fill_cnt == FILL_LAST) begin
                            st        <= VERIFY;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        shreg <= {shreg[WIDTH-2:0], bitIn};
                        // An all-zero register trivially predicts zeros.
                        if (bitIn == pred && shreg != '0) begin
                            if (match_cnt == MATCH_LAST) begin
                                st        <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so a bad bit is
                        // counted once and never enters the register.
                        shreg <= {shreg[WIDTH-2:0], pred};
                        if (bitIn != pred) begin
                            errPulse <= 1'b1;
                            if (!clearErr && err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (miss_cnt == MISS_LAST) begin
                                st       <= FILL;
                                locked   <= 1'b0;
                                fill_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        st     <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: expected outputs are queued as each
// bit is driven and compared one edge later.
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        bitIn;
    logic        bitValid;
    logic [7:0]  tapIn;
    logic        tapEn;
    logic        clearErr;
    logic        locked;
    logic        errPulse;
    logic [15:0] errCount;
    logic [1:0]  state;
    logic        locked_s;
    logic        errPulse_s;
    logic [3:0]  errCount_s;
    logic [1:0]  state_s;

    prbs_checker dut (
        .clock(clock), .reset(reset), .bitIn(bitIn),
        .bitValid(bitValid), .tapIn(tapIn), .tapEn(tapEn),
        .clearErr(clearErr), .locked(locked), .errPulse(errPulse),
        .errCount(errCount), .state(state)
    );

    // Narrow counter copy on the same inputs exposes saturation quickly.
    prbs_checker #(.ERR_CNT_W(4)) dut_s (
        .clock(clock), .reset(reset), .bitIn(bitIn),
        .bitValid(bitValid), .tapIn(tapIn), .tapEn(tapEn),
        .clearErr(clearErr), .locked(locked_s), .errPulse(errPulse_s),
        .errCount(errCount_s), .state(state_s)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  st;
        logic        ep;
        logic [15:0] ec;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  g;
    logic [15:0] e_ec;
    logic        b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (sb.size() > 0) begin
            #1;
            cur = sb.pop_front();
            chk("state", 32'(state), 32'(cur.st));
            chk("locked", 32'(locked), 32'(cur.st == 2'd2));
            chk("errPulse", 32'(errPulse), 32'(cur.ep));
            chk("errCount", 32'(errCount), 32'(cur.ec));
            chk("errCount_sat", 32'(errCount_s),
                (cur.ec > 16'd15) ? 32'd15 : 32'(cur.ec));
            chk("state_s", 32'(state_s), 32'(cur.st));
            chk("locked_s", 32'(locked_s), 32'(cur.st == 2'd2));
            chk("errPulse_s", 32'(errPulse_s), 32'(cur.ep));
        end
    end

    task automatic gbit(output logic o);
        o = ^(g & 8'hB8);
        g = {g[6:0], o};
    endtask

    task automatic drive(input logic bi, input logic v, input logic te,
                         input logic ce, input logic [1:0] est,
                         input logic eep, input logic [15:0] eec);
        bitIn    = bi;
        bitValid = v;
        tapEn    = te;
        clearErr = ce;
        sb.push_back('{st: est, ep: eep, ec: eec});
        @(posedge clock);
        #2;
        bitValid = 1'b0;
        tapEn    = 1'b0;
        clearErr = 1'b0;
    endtask

    task automatic lock_run();
        for (int i = 0; i < 24; i++) begin
            gbit(b);
            drive(b, 1'b1, 1'b0, 1'b0,
                  (i < 7) ? 2'd0 : (i < 23) ? 2'd1 : 2'd2, 1'b0, e_ec);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            gbit(b);
            drive(b, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, e_ec);
        end
    endtask

    task automatic bad(input int n);
        for (int k = 0; k < n; k++) begin
            gbit(b);
            if (e_ec != 16'hFFFF) e_ec = e_ec + 16'd1;
            drive(~b, 1'b1, 1'b0, 1'b0,
                  (k == 3) ? 2'd0 : 2'd2, 1'b1, e_ec);
        end
    endtask

    task automatic idle(input int n, input logic [1:0] est);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, est, 1'b0, e_ec);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        bitIn    = 1'b0;
        bitValid = 1'b0;
        tapIn    = 8'h00;
        tapEn    = 1'b0;
        clearErr = 1'b0;
        e_ec     = 16'd0;
        g        = 8'h01;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_errPulse", 32'(errPulse), 32'd0);
        chk("rst_errCount", 32'(errCount), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;

        // All-zero stream never locks.
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0,
                  (i < 7) ? 2'd0 : 2'd1, 1'b0, 16'd0);
        end

        // Acquire on the seeded generator stream.
        do_reset();
        g = 8'h01;
        lock_run();

        // Single error, idle gaps, no multiplication.
        clean(10);
        idle(2, 2'd2);
        bad(1);
        idle(1, 2'd2);
        clean(100);

        // Clear, then four consecutive errors drop lock; re-acquire.
        e_ec = 16'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0);
        bad(4);
        lock_run();
        clean(5);

        // tapEn restarts acquisition, errCount held, bit ignored.
        tapIn = 8'h8E;
        gbit(b);
        drive(~b, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, e_ec);
        // tapEn and clearErr together both act.
        tapIn = 8'hB8;
        e_ec  = 16'd0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16'd0);
        lock_run();
        bad(1);
        clean(1);
        // clearErr wins over a same-cycle error, pulse still fires.
        gbit(b);
        e_ec = 16'd0;
        drive(~b, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 16'd0);
        clean(2);

        // Error bursts below the loss threshold push the count past
        // the narrow counter's saturation point.
        for (int r = 0; r < 6; r++) begin
            bad(3);
            clean(1);
        end

        // Asynchronous reset mid-stream with bitValid toggling.
        for (int i = 0; i < 4; i++) begin
            gbit(b);
            drive(b, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, e_ec);
            idle(1, 2'd2);
        end
        bitIn    = 1'b1;
        bitValid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_errPulse", 32'(errPulse), 32'd0);
        chk("arst_errCount", 32'(errCount), 32'd0);
        chk("arst_errCount_s", 32'(errCount_s), 32'd0);
        bitValid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clock);
            #2;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
